first_fit_walker: RTL and testbench



---
 rtl/allocator_pkg.sv | 52 +++++
 rtl/lsu_req_issuer.sv | 34 +++
 rtl/first_fit_walker.sv | 253 +++++++++++++++++++++++++
 tb/tb_first_fit_walker.sv | 398 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/allocator_pkg.sv
// Shared allocator types: LSU header request/response structs, op codes and walker states.
package allocator_pkg;

    localparam int DATA_W                 = 32;
    localparam int BLOCK_NEXT_ADDR_OFFSET = 4;

    typedef enum logic [1:0] {
        LOCK   = 2'd0,
        LOAD   = 2'd1,
        INSERT = 2'd2,
        DELETE = 2'd3
    } lsu_op_e;

    typedef struct packed {
        logic [DATA_W-1:0] addr;
        logic [DATA_W-1:0] size;
        logic [DATA_W-1:0] next_addr;
    } header_data_t;

    typedef struct packed {
        logic         val;
        lsu_op_e      lsu_op;
        header_data_t header_data;
    } header_data_req_t;

    typedef struct packed {
        logic         val;
        header_data_t header_data;
    } header_data_rsp_t;

    typedef enum logic [3:0] {
        IDLE      = 4'd0,
        LD_HEAD   = 4'd1,
        LD_HEAD_W = 4'd2,
        LD_CUR    = 4'd3,
        LD_CUR_W  = 4'd4,
        INS       = 4'd5,
        INS_W     = 4'd6,
        UNLINK    = 4'd7,
        UNLINK_W  = 4'd8,
        RSP       = 4'd9
    } ffw_state_e;

    // Returns {carry, rounded}; a set carry means the round-up wrapped past DATA_W.
    function automatic logic [DATA_W:0] round_up(input logic [DATA_W-1:0] size,
                                                 input int align);
        logic [DATA_W:0] sum;
        sum = {1'b0, size} + (DATA_W+1)'(align - 1);
        return {sum[DATA_W], sum[DATA_W-1:0] & ~DATA_W'(align - 1)};
    endfunction

endpackage

// File: rtl/lsu_req_issuer.sv
// One-shot LSU request driver: presents a request only while the LSU is ready,
// and accepts the matching response while the walker sits in a wait state.
module lsu_req_issuer
    import allocator_pkg::*;
(
    input  logic             issue,
    input  lsu_op_e          op,
    input  header_data_t     hdr,
    input  logic             wait_rsp,
    input  logic             lsu_ready_i,
    output header_data_req_t lsu_req_o,
    input  header_data_rsp_t lsu_rsp_i,
    output logic             lsu_rsp_rdy_o,
    output logic             sent,
    output logic             done,
    output header_data_t     rsp_hdr
);

    // The bus is held at zero outside the single transfer cycle.
    always_comb begin
        lsu_req_o = '0;
        if (issue && lsu_ready_i) begin
            lsu_req_o.val         = 1'b1;
            lsu_req_o.lsu_op      = op;
            lsu_req_o.header_data = hdr;
        end
    end

    assign sent          = lsu_req_o.val;
    assign lsu_rsp_rdy_o = wait_rsp;
    assign done          = wait_rsp && lsu_rsp_i.val;
    assign rsp_hdr       = lsu_rsp_i.header_data;

endmodule

// File: rtl/first_fit_walker.sv
// First-fit free-list walker for the falafel allocator front end.
// Define FFW_SPLIT_EN to split oversized blocks instead of handing them out whole.
module first_fit_walker
    import allocator_pkg::*;
#(
    parameter int                ALIGN          = 8,
    parameter int                MIN_BLOCK_SIZE = 16,
    parameter logic [DATA_W-1:0] HEAD_ADDR      = '0,
    parameter int                MAX_HOPS       = 1024
)(
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              alloc_req_val_i,
    output logic              alloc_req_rdy_o,
    input  logic [DATA_W-1:0] alloc_req_size_i,
    output logic              alloc_rsp_val_o,
    input  logic              alloc_rsp_rdy_i,
    output logic [DATA_W-1:0] alloc_rsp_addr_o,
    output logic              alloc_rsp_ok_o,
    output header_data_req_t  lsu_req_o,
    input  logic              lsu_ready_i,
    input  header_data_rsp_t  lsu_rsp_i,
    output logic              lsu_rsp_rdy_o
);

    localparam int HOP_W = $clog2(MAX_HOPS + 1);

    ffw_state_e        state_q, state_d;
    logic [DATA_W-1:0] req_q, req_d;
    logic [DATA_W-1:0] prev_q, prev_d;
    logic [DATA_W-1:0] cur_q, cur_d;
    logic [DATA_W-1:0] link_q, link_d;
    logic [HOP_W-1:0]  hops_q, hops_d, hops_nxt;
    logic [DATA_W-1:0] rsp_addr_q, rsp_addr_d;
    logic              rsp_ok_q, rsp_ok_d;

    logic [DATA_W:0]   rnd;
    logic [DATA_W-1:0] rnd_req;
    logic              rnd_bad;

    logic              issue, wait_rsp, sent, done;
    lsu_op_e           op;
    header_data_t      hdr, rsp_hdr;

    assign rnd      = round_up(alloc_req_size_i, ALIGN);
    assign rnd_req  = rnd[DATA_W-1:0];
    assign rnd_bad  = rnd[DATA_W] || (rnd_req == '0);
    assign hops_nxt = hops_q + HOP_W'(1);

`ifdef FFW_SPLIT_EN
    logic [DATA_W-1:0] cur_size_q, cur_size_d;
    logic [DATA_W-1:0] cur_next_q, cur_next_d;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cur_size_q <= '0;
            cur_next_q <= '0;
        end else begin
            cur_size_q <= cur_size_d;
            cur_next_q <= cur_next_d;
        end
    end
`else
    logic [DATA_W-1:0] unused_min_block;
    assign unused_min_block = DATA_W'(MIN_BLOCK_SIZE);
`endif

    // The LSU echoes the header address on every response; only size/next matter here.
    logic unused_rsp_addr;
    assign unused_rsp_addr = ^rsp_hdr.addr;

    lsu_req_issuer u_issuer (
        .issue         (issue),
        .op            (op),
        .hdr           (hdr),
        .wait_rsp      (wait_rsp),
        .lsu_ready_i   (lsu_ready_i),
        .lsu_req_o     (lsu_req_o),
        .lsu_rsp_i     (lsu_rsp_i),
        .lsu_rsp_rdy_o (lsu_rsp_rdy_o),
        .sent          (sent),
        .done          (done),
        .rsp_hdr       (rsp_hdr)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            req_q      <= '0;
            prev_q     <= '0;
            cur_q      <= '0;
            link_q     <= '0;
            hops_q     <= '0;
            rsp_addr_q <= '0;
            rsp_ok_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            req_q      <= req_d;
            prev_q     <= prev_d;
            cur_q      <= cur_d;
            link_q     <= link_d;
            hops_q     <= hops_d;
            rsp_addr_q <= rsp_addr_d;
            rsp_ok_q   <= rsp_ok_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        req_d      = req_q;
        prev_d     = prev_q;
        cur_d      = cur_q;
        link_d     = link_q;
        hops_d     = hops_q;
        rsp_addr_d = rsp_addr_q;
        rsp_ok_d   = rsp_ok_q;
`ifdef FFW_SPLIT_EN
        cur_size_d = cur_size_q;
        cur_next_d = cur_next_q;
`endif
        issue      = 1'b0;
        wait_rsp   = 1'b0;
        op         = LOAD;
        hdr        = '0;

        case (state_q)
            IDLE: begin
                if (alloc_req_val_i) begin
                    req_d  = rnd_req;
                    prev_d = HEAD_ADDR;
                    hops_d = '0;
                    if (rnd_bad) begin
                        rsp_addr_d = '0;
                        rsp_ok_d   = 1'b0;
                        state_d    = RSP;
                    end else begin
                        state_d = LD_HEAD;
                    end
                end
            end

            LD_HEAD: begin
                issue    = 1'b1;
                hdr.addr = HEAD_ADDR;
                if (sent) state_d = LD_HEAD_W;
            end

            LD_HEAD_W: begin
                wait_rsp = 1'b1;
                if (done) begin
                    cur_d = rsp_hdr.next_addr;
                    if (rsp_hdr.next_addr == '0) begin
                        rsp_addr_d = '0;
                        rsp_ok_d   = 1'b0;
                        state_d    = RSP;
                    end else begin
                        state_d = LD_CUR;
                    end
                end
            end

            LD_CUR: begin
                issue    = 1'b1;
                hdr.addr = cur_q;
                if (sent) state_d = LD_CUR_W;
            end

            LD_CUR_W: begin
                wait_rsp = 1'b1;
                if (done) begin
                    hops_d = hops_nxt;
`ifdef FFW_SPLIT_EN
                    cur_size_d = rsp_hdr.size;
                    cur_next_d = rsp_hdr.next_addr;
`endif
                    if (rsp_hdr.size < req_q) begin
                        // Too small: advance, unless the list or the hop budget is exhausted.
                        if (rsp_hdr.next_addr == '0 || hops_nxt == HOP_W'(MAX_HOPS)) begin
                            rsp_addr_d = '0;
                            rsp_ok_d   = 1'b0;
                            state_d    = RSP;
                        end else begin
                            prev_d  = cur_q;
                            cur_d   = rsp_hdr.next_addr;
                            state_d = LD_CUR;
                        end
                    end else begin
`ifdef FFW_SPLIT_EN
                        if (rsp_hdr.size - req_q >= DATA_W'(MIN_BLOCK_SIZE)) begin
                            state_d = INS;
                        end else begin
                            link_d  = rsp_hdr.next_addr;
                            state_d = UNLINK;
                        end
`else
                        link_d  = rsp_hdr.next_addr;
                        state_d = UNLINK;
`endif
                    end
                end
            end

`ifdef FFW_SPLIT_EN
            // The tail of the chosen block becomes a fresh free block in its place.
            INS: begin
                issue         = 1'b1;
                op            = INSERT;
                hdr.addr      = cur_q + req_q;
                hdr.size      = cur_size_q - req_q;
                hdr.next_addr = cur_next_q;
                if (sent) state_d = INS_W;
            end

            INS_W: begin
                wait_rsp = 1'b1;
                if (done) begin
                    link_d  = cur_q + req_q;
                    state_d = UNLINK;
                end
            end
`endif

            UNLINK: begin
                issue         = 1'b1;
                op            = DELETE;
                hdr.addr      = prev_q;
                hdr.next_addr = link_q;
                if (sent) state_d = UNLINK_W;
            end

            UNLINK_W: begin
                wait_rsp = 1'b1;
                if (done) begin
                    rsp_addr_d = cur_q;
                    rsp_ok_d   = 1'b1;
                    state_d    = RSP;
                end
            end

            RSP: begin
                if (alloc_rsp_rdy_i) state_d = IDLE;
            end

            default: state_d = IDLE;
        endcase
    end

    assign alloc_req_rdy_o  = (state_q == IDLE);
    assign alloc_rsp_val_o  = (state_q == RSP);
    assign alloc_rsp_addr_o = rsp_addr_q;
    assign alloc_rsp_ok_o   = rsp_ok_q;

endmodule

// File: tb/tb_first_fit_walker.sv
// Directed bench for first_fit_walker against a zero-wait header LSU model.
module tb_first_fit_walker;
    import allocator_pkg::*;

    logic              clk_i = 1'b0;
    logic              rst_i;
    logic              alloc_req_val_i;
    logic              alloc_req_rdy_o;
    logic [DATA_W-1:0] alloc_req_size_i;
    logic              alloc_rsp_val_o;
    logic              alloc_rsp_rdy_i;
    logic [DATA_W-1:0] alloc_rsp_addr_o;
    logic              alloc_rsp_ok_o;
    header_data_req_t  lsu_req_o;
    logic              lsu_ready_i;
    header_data_rsp_t  lsu_rsp_i;
    logic              lsu_rsp_rdy_o;

    first_fit_walker #(
        .ALIGN          (8),
        .MIN_BLOCK_SIZE (16),
        .HEAD_ADDR      (32'h0),
        .MAX_HOPS       (1024)
    ) dut (
        .clk_i            (clk_i),
        .rst_i            (rst_i),
        .alloc_req_val_i  (alloc_req_val_i),
        .alloc_req_rdy_o  (alloc_req_rdy_o),
        .alloc_req_size_i (alloc_req_size_i),
        .alloc_rsp_val_o  (alloc_rsp_val_o),
        .alloc_rsp_rdy_i  (alloc_rsp_rdy_i),
        .alloc_rsp_addr_o (alloc_rsp_addr_o),
        .alloc_rsp_ok_o   (alloc_rsp_ok_o),
        .lsu_req_o        (lsu_req_o),
        .lsu_ready_i      (lsu_ready_i),
        .lsu_rsp_i        (lsu_rsp_i),
        .lsu_rsp_rdy_o    (lsu_rsp_rdy_o)
    );

    always #5 clk_i = ~clk_i;

    int checks = 0;
    int errors = 0;

    typedef struct {
        lsu_op_e     op;
        logic [31:0] addr;
        logic [31:0] size;
        logic [31:0] next_addr;
    } op_rec_t;

    logic [31:0]      mem_size [logic [31:0]];
    logic [31:0]      mem_next [logic [31:0]];
    op_rec_t          op_log[$];
    int               bad_issue = 0;
    logic             init_mem = 1'b0;
    header_data_rsp_t rsp_q;
    header_data_t     hd;
    op_rec_t          rec;

    assign lsu_rsp_i = rsp_q;

    // Header LSU model: captures a request on the transfer edge, answers next cycle.
    always @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rsp_q <= '0;
        end else if (init_mem) begin
            mem_size.delete();
            mem_next.delete();
            mem_size[32'h000] = 32'h0;   mem_next[32'h000] = 32'h100;
            mem_size[32'h100] = 32'h40;  mem_next[32'h100] = 32'h200;
            mem_size[32'h200] = 32'h400; mem_next[32'h200] = 32'h0;
            rsp_q <= '0;
        end else begin
            if (rsp_q.val && lsu_rsp_rdy_o) rsp_q <= '0;
            if (lsu_req_o.val) begin
                if (!lsu_ready_i) bad_issue <= bad_issue + 1;
                rec.op        = lsu_req_o.lsu_op;
                rec.addr      = lsu_req_o.header_data.addr;
                rec.size      = lsu_req_o.header_data.size;
                rec.next_addr = lsu_req_o.header_data.next_addr;
                op_log.push_back(rec);
                hd = lsu_req_o.header_data;
                case (lsu_req_o.lsu_op)
                    LOAD: begin
                        hd.size      = mem_size.exists(rec.addr) ? mem_size[rec.addr] : 32'h0;
                        hd.next_addr = mem_next.exists(rec.addr) ? mem_next[rec.addr] : 32'h0;
                    end
                    INSERT: begin
                        mem_size[rec.addr] = rec.size;
                        mem_next[rec.addr] = rec.next_addr;
                    end
                    DELETE: mem_next[rec.addr] = rec.next_addr;
                    default: ;
                endcase
                rsp_q <= '{val: 1'b1, header_data: hd};
            end
        end
    end

    task automatic load_image();
        @(negedge clk_i);
        init_mem = 1'b1;
        @(posedge clk_i);
        #1 init_mem = 1'b0;
    endtask

    task automatic send_req(input logic [31:0] sz);
        @(negedge clk_i);
        alloc_req_val_i  = 1'b1;
        alloc_req_size_i = sz;
        @(posedge clk_i);
        #1;
        alloc_req_val_i  = 1'b0;
        alloc_req_size_i = 32'hDEAD_BEEF;
    endtask

    task automatic wait_rsp(output int lat, output bit to);
        lat = 0;
        to  = 1'b1;
        for (int i = 1; i <= 200; i++) begin
            @(negedge clk_i);
            if (alloc_rsp_val_o) begin
                lat = i;
                to  = 1'b0;
                break;
            end
        end
    endtask

    task automatic run_alloc(input logic [31:0] sz, output logic [31:0] a, output logic k,
                             output int lat, output bit to);
        send_req(sz);
        wait_rsp(lat, to);
        a = alloc_rsp_addr_o;
        k = alloc_rsp_ok_o;
        @(posedge clk_i);
        #1;
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        alloc_req_val_i = 1'b0; alloc_req_size_i = '0;
        alloc_rsp_rdy_i = 1'b1; lsu_ready_i = 1'b1;
        repeat (2) @(posedge clk_i);
        #1;
        checks++;
        if (alloc_req_rdy_o !== 1'b1 || alloc_rsp_val_o !== 1'b0 || lsu_rsp_rdy_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_hs: req_rdy=%b rsp_val=%b lsu_rsp_rdy=%b, want 1 0 0",
                     alloc_req_rdy_o, alloc_rsp_val_o, lsu_rsp_rdy_o);
        end
        checks++;
        if (alloc_rsp_addr_o !== 32'h0 || alloc_rsp_ok_o !== 1'b0 || lsu_req_o !== '0) begin
            errors++;
            $display("FAIL reset_data: addr=%h ok=%b lsu_req=%h, want 0 0 0",
                     alloc_rsp_addr_o, alloc_rsp_ok_o, lsu_req_o);
        end
        @(negedge clk_i);
        rst_i = 1'b0;
    endtask

    task automatic test_first_fit();
        logic [31:0] a; logic k; int lat; bit to; int base, n_exp;
        op_rec_t e;
        load_image();
        base = op_log.size();
        run_alloc(32'h300, a, k, lat, to);
`ifdef FFW_SPLIT_EN
        n_exp = 5;
        e = '{op: DELETE, addr: 32'h100, size: 32'h0, next_addr: 32'h500};
        checks++;
        if (op_log[base+3].op !== INSERT || op_log[base+3].addr !== 32'h500 ||
            op_log[base+3].size !== 32'h100 || op_log[base+3].next_addr !== 32'h0) begin
            errors++;
            $display("FAIL first_fit_insert: got op=%0d addr=%h size=%h next=%h, want op=2 addr=500 size=100 next=0",
                     op_log[base+3].op, op_log[base+3].addr, op_log[base+3].size, op_log[base+3].next_addr);
        end
`else
        n_exp = 4;
        e = '{op: DELETE, addr: 32'h100, size: 32'h0, next_addr: 32'h0};
`endif
        checks++;
        if (to || a !== 32'h200 || k !== 1'b1) begin
            errors++;
            $display("FAIL first_fit_rsp: addr=%h ok=%b timeout=%0d, want addr=200 ok=1", a, k, to);
        end
        checks++;
        if (op_log.size() - base != n_exp) begin
            errors++;
            $display("FAIL first_fit_nops: got %0d ops, want %0d", op_log.size() - base, n_exp);
        end
        checks++;
        if (op_log[base+n_exp-1].op !== e.op || op_log[base+n_exp-1].addr !== e.addr ||
            op_log[base+n_exp-1].next_addr !== e.next_addr) begin
            errors++;
            $display("FAIL first_fit_delete: got op=%0d addr=%h next=%h, want op=%0d addr=%h next=%h",
                     op_log[base+n_exp-1].op, op_log[base+n_exp-1].addr, op_log[base+n_exp-1].next_addr,
                     e.op, e.addr, e.next_addr);
        end
    endtask

    task automatic test_exact_fit();
        logic [31:0] a; logic k; int lat; bit to; int base;
        load_image();
        base = op_log.size();
        run_alloc(32'h3F, a, k, lat, to);
        checks++;
        if (to || a !== 32'h100 || k !== 1'b1) begin
            errors++;
            $display("FAIL exact_fit_rsp: addr=%h ok=%b timeout=%0d, want addr=100 ok=1", a, k, to);
        end
        checks++;
        if (lat != 7) begin
            errors++;
            $display("FAIL exact_fit_latency: got %0d cycles, want 7", lat);
        end
        checks++;
        if (op_log.size() - base != 3 || op_log[base+2].op !== DELETE ||
            op_log[base+2].addr !== 32'h0 || op_log[base+2].next_addr !== 32'h200) begin
            errors++;
            $display("FAIL exact_fit_ops: n=%0d last op=%0d addr=%h next=%h, want n=3 op=3 addr=0 next=200",
                     op_log.size() - base, op_log[base+2].op, op_log[base+2].addr, op_log[base+2].next_addr);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] a; logic k; int lat; bit to; int base, n_exp;
        logic [31:0] e_next;
        // Memory still holds the list left by the exact-fit allocation: head -> B.
        base = op_log.size();
        run_alloc(32'h3F, a, k, lat, to);
`ifdef FFW_SPLIT_EN
        n_exp = 4; e_next = 32'h240;
        checks++;
        if (op_log[base+2].op !== INSERT || op_log[base+2].addr !== 32'h240 ||
            op_log[base+2].size !== 32'h3C0 || op_log[base+2].next_addr !== 32'h0) begin
            errors++;
            $display("FAIL b2b_insert: got op=%0d addr=%h size=%h next=%h, want op=2 addr=240 size=3c0 next=0",
                     op_log[base+2].op, op_log[base+2].addr, op_log[base+2].size, op_log[base+2].next_addr);
        end
`else
        n_exp = 3; e_next = 32'h0;
`endif
        checks++;
        if (to || a !== 32'h200 || k !== 1'b1 || op_log.size() - base != n_exp) begin
            errors++;
            $display("FAIL b2b_rsp: addr=%h ok=%b timeout=%0d ops=%0d, want addr=200 ok=1 ops=%0d",
                     a, k, to, op_log.size() - base, n_exp);
        end
        checks++;
        if (op_log[base+n_exp-1].op !== DELETE || op_log[base+n_exp-1].addr !== 32'h0 ||
            op_log[base+n_exp-1].next_addr !== e_next) begin
            errors++;
            $display("FAIL b2b_delete: got op=%0d addr=%h next=%h, want op=3 addr=0 next=%h",
                     op_log[base+n_exp-1].op, op_log[base+n_exp-1].addr,
                     op_log[base+n_exp-1].next_addr, e_next);
        end
    endtask

    task automatic test_whole_block();
        logic [31:0] a; logic k; int lat; bit to; int base;
        load_image();
        base = op_log.size();
        run_alloc(32'h3F8, a, k, lat, to);
        checks++;
        if (to || a !== 32'h200 || k !== 1'b1) begin
            errors++;
            $display("FAIL whole_rsp: addr=%h ok=%b timeout=%0d, want addr=200 ok=1", a, k, to);
        end
        checks++;
        if (op_log.size() - base != 4 || op_log[base+3].op !== DELETE ||
            op_log[base+3].addr !== 32'h100 || op_log[base+3].next_addr !== 32'h0) begin
            errors++;
            $display("FAIL whole_ops: n=%0d last op=%0d addr=%h next=%h, want n=4 op=3 addr=100 next=0",
                     op_log.size() - base, op_log[base+3].op, op_log[base+3].addr, op_log[base+3].next_addr);
        end
    endtask

    task automatic test_no_fit();
        logic [31:0] a; logic k; int lat; bit to; int base, loads;
        load_image();
        base = op_log.size();
        run_alloc(32'h1000, a, k, lat, to);
        loads = 0;
        for (int i = base; i < op_log.size(); i++)
            if (op_log[i].op == LOAD) loads++;
        checks++;
        if (to || a !== 32'h0 || k !== 1'b0) begin
            errors++;
            $display("FAIL no_fit_rsp: addr=%h ok=%b timeout=%0d, want addr=0 ok=0", a, k, to);
        end
        checks++;
        if (op_log.size() - base != 3 || loads != 3) begin
            errors++;
            $display("FAIL no_fit_ops: ops=%0d loads=%0d, want 3 3", op_log.size() - base, loads);
        end
    endtask

    task automatic test_immediate_fail();
        logic [31:0] a; logic k; int lat; bit to; int base;
        logic [31:0] sizes [2];
        sizes[0] = 32'h0;
        sizes[1] = 32'hFFFF_FFFC;
        for (int t = 0; t < 2; t++) begin
            base = op_log.size();
            run_alloc(sizes[t], a, k, lat, to);
            checks++;
            if (to || lat != 1 || a !== 32'h0 || k !== 1'b0 || op_log.size() != base) begin
                errors++;
                $display("FAIL immediate_fail size=%h: lat=%0d addr=%h ok=%b ops=%0d timeout=%0d, want lat=1 addr=0 ok=0 ops=0",
                         sizes[t], lat, a, k, op_log.size() - base, to);
            end
        end
    endtask

    task automatic test_stall();
        logic [31:0] a; logic k; int lat; bit to; int base, bad0, leaked, unstable;
        load_image();
        base = op_log.size();
        bad0 = bad_issue;
        lsu_ready_i     = 1'b0;
        alloc_rsp_rdy_i = 1'b0;
        send_req(32'h3F);
        leaked = 0;
        repeat (4) begin
            @(negedge clk_i);
            if (lsu_req_o.val !== 1'b0) leaked++;
        end
        lsu_ready_i = 1'b1;
        checks++;
        if (leaked != 0 || op_log.size() != base) begin
            errors++;
            $display("FAIL stall_no_issue: val high %0d cycles, ops=%0d, want 0 0", leaked, op_log.size() - base);
        end
        wait_rsp(lat, to);
        a = alloc_rsp_addr_o;
        k = alloc_rsp_ok_o;
        unstable = 0;
        repeat (5) begin
            @(negedge clk_i);
            if (alloc_rsp_val_o !== 1'b1 || alloc_rsp_addr_o !== a || alloc_rsp_ok_o !== k) unstable++;
        end
        checks++;
        if (to || a !== 32'h100 || k !== 1'b1 || unstable != 0) begin
            errors++;
            $display("FAIL stall_rsp_hold: addr=%h ok=%b unstable=%0d timeout=%0d, want addr=100 ok=1 unstable=0",
                     a, k, unstable, to);
        end
        alloc_rsp_rdy_i = 1'b1;
        @(posedge clk_i);
        #1;
        checks++;
        if (alloc_rsp_val_o !== 1'b0 || alloc_req_rdy_o !== 1'b1 || bad_issue != bad0) begin
            errors++;
            $display("FAIL stall_release: rsp_val=%b req_rdy=%b bad_issue=%0d, want 0 1 0",
                     alloc_rsp_val_o, alloc_req_rdy_o, bad_issue - bad0);
        end
    endtask

    task automatic test_reset_mid_walk();
        load_image();
        send_req(32'h3F);
        repeat (3) @(negedge clk_i);
        rst_i = 1'b1;
        #1;
        checks++;
        if (alloc_req_rdy_o !== 1'b1 || alloc_rsp_val_o !== 1'b0 || lsu_req_o.val !== 1'b0 ||
            lsu_rsp_rdy_o !== 1'b0) begin
            errors++;
            $display("FAIL mid_walk_reset: req_rdy=%b rsp_val=%b lsu_val=%b lsu_rsp_rdy=%b, want 1 0 0 0",
                     alloc_req_rdy_o, alloc_rsp_val_o, lsu_req_o.val, lsu_rsp_rdy_o);
        end
        @(negedge clk_i);
        rst_i = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not reach the summary");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_first_fit();
        test_exact_fit();
        test_back_to_back();
        test_whole_block();
        test_no_fit();
        test_immediate_fail();
        test_stall();
        test_reset_mid_walk();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
